// File: rtl/seq_mul_dispatch.sv
// seq_mul_dispatch: job dispatcher and result collector for a sequential
// shift-add multiplier.
//   in_*       valid/ready operand intake into a DEPTH-entry FIFO
//   mul_*      launch/hold interface to the multiplier (start low = idle)
//   out_*      one-entry result register with valid/ready, out_err on timeout
//   fifo_count queued entries; busy = FSM not idle
module seq_mul_dispatch #(
    parameter int unsigned N       = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 72
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_mcand,
    input  logic [N-1:0]             in_mlier,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*N-1:0]           out_prod,
    output logic                     out_err,
    output logic                     mul_start,
    output logic [N-1:0]             mul_mcand,
    output logic [N-1:0]             mul_mlier,
    input  logic                     mul_valid,
    input  logic [2*N:0]             mul_prod,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2*N-1:0]    mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              start_q, start_d;
    logic [N-1:0]      mcand_q, mcand_d, mlier_q, mlier_d;
    logic              out_valid_q, out_valid_d;
    logic [2*N-1:0]    out_prod_q, out_prod_d;
    logic              out_err_q, out_err_d;
    logic              push, pop, slot_free;

    // Carry bit of the multiplier is always 0 for N-bit operands.
    logic              unused_carry;
    assign unused_carry = mul_prod[2*N];

    // Rejected while full even if a pop lands the same cycle.
    assign push      = in_valid && in_ready_q;
    assign slot_free = !out_valid_q || out_ready;

    // Next-state for FSM, multiplier drive, output slot and FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        start_d     = start_q;
        mcand_d     = mcand_q;
        mlier_d     = mlier_q;
        out_valid_d = out_valid_q;
        out_prod_d  = out_prod_q;
        out_err_d   = out_err_q;
        pop         = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                start_d = 1'b0;
                if (count_q != '0 && !out_valid_q) begin
                    pop     = 1'b1;
                    mcand_d = mem_q[rd_ptr_q][2*N-1:N];
                    mlier_d = mem_q[rd_ptr_q][N-1:0];
                    start_d = 1'b1;
                    timer_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Completion beats timeout; both wait for a free output slot.
                if (mul_valid || timer_q == TW'(TIMEOUT - 1)) begin
                    if (slot_free) begin
                        out_valid_d = 1'b1;
                        out_err_d   = !mul_valid;
                        out_prod_d  = mul_valid ? mul_prod[2*N-1:0] : '0;
                        start_d     = 1'b0;
                        state_d     = DRAIN;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DRAIN: begin
                // One cycle of start low lets the multiplier clear its valid.
                start_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        in_ready_d = (count_d != CW'(DEPTH));
        busy_d     = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            timer_q     <= '0;
            start_q     <= 1'b0;
            mcand_q     <= '0;
            mlier_q     <= '0;
            out_valid_q <= 1'b0;
            out_prod_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            timer_q     <= timer_d;
            start_q     <= start_d;
            mcand_q     <= mcand_d;
            mlier_q     <= mlier_d;
            out_valid_q <= out_valid_d;
            out_prod_q  <= out_prod_d;
            out_err_q   <= out_err_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_mcand, in_mlier};
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign mul_start  = start_q;
    assign mul_mcand  = mcand_q;
    assign mul_mlier  = mlier_q;
    assign out_valid  = out_valid_q;
    assign out_prod   = out_prod_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_seq_mul_dispatch.sv
// Bench for seq_mul_dispatch: a behavioural multiplier with random latency
// drives mul_valid/mul_prod; a monitor tracks expected FIFO occupancy and an
// in-order queue of expected results.
module tb_seq_mul_dispatch;
    localparam int unsigned N       = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 72;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid, in_ready;
    logic [N-1:0]    in_mcand, in_mlier;
    logic            out_valid, out_ready, out_err;
    logic [2*N-1:0]  out_prod;
    logic            mul_start, mul_valid;
    logic [N-1:0]    mul_mcand, mul_mlier;
    logic [2*N:0]    mul_prod;
    logic [CW-1:0]   fifo_count;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    logic rand_rdy = 1'b0;
    logic rnd_rdy  = 1'b0;
    logic dir_rdy  = 1'b1;
    logic mul_en   = 1'b1;
    logic timeout_mode = 1'b0;
    assign out_ready = rand_rdy ? rnd_rdy : dir_rdy;

    seq_mul_dispatch #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mcand(in_mcand), .in_mlier(in_mlier),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .out_err(out_err),
        .mul_start(mul_start), .mul_mcand(mul_mcand), .mul_mlier(mul_mlier),
        .mul_valid(mul_valid), .mul_prod(mul_prod),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clock = ~clock;

    always begin
        @(posedge clock);
        #1 rnd_rdy = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Multiplier stand-in: random latency after start, valid held while start stays high.
    int unsigned mcnt, mlat;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mcnt <= 0; mlat <= 2; mul_valid <= 1'b0; mul_prod <= '0;
        end else if (!mul_start) begin
            mcnt <= 0; mul_valid <= 1'b0;
        end else begin
            if (mcnt == 0) mlat <= $urandom_range(2, 40);
            if (mcnt < 1000) mcnt <= mcnt + 1;
            mul_valid <= mul_en && (mcnt != 0) && (mcnt >= mlat);
            mul_prod  <= {1'($urandom_range(0, 1)), 64'(mul_mcand) * 64'(mul_mlier)};
        end
    end

    // Monitor: occupancy model, operand/result hold checks, in-order scoreboard.
    logic [64:0]     exp_q[$];
    int              ref_count = 0;
    int              n_done = 0;
    int              low_cnt = 0;
    logic            first_launch = 1'b1;
    logic            prev_start = 1'b0, prev_hold = 1'b0;
    logic [N-1:0]    prev_mcand, prev_mlier;
    logic [2*N-1:0]  prev_prod, last_prod;
    logic            prev_err, last_err;
    always @(negedge clock) begin
        if (reset !== 1'b0) begin
            exp_q.delete();
            ref_count = 0; low_cnt = 0; first_launch = 1'b1;
            prev_start = 1'b0; prev_hold = 1'b0;
        end else begin
            if (mul_start && !prev_start) begin
                ref_count--;
                if (!first_launch) chk("start_gap_ge2", low_cnt >= 2, 1);
                first_launch = 1'b0;
                low_cnt = 0;
            end
            if (!mul_start) low_cnt++;
            if (mul_start && prev_start) begin
                chk("mcand_hold", mul_mcand, prev_mcand);
                chk("mlier_hold", mul_mlier, prev_mlier);
            end
            chk("fifo_count", fifo_count, ref_count);
            chk("in_ready", in_ready, ref_count != DEPTH);
            if (prev_hold) begin
                chk("out_prod_hold", out_prod, prev_prod);
                chk("out_err_hold", out_err, prev_err);
            end
            if (out_valid && out_ready) begin
                chk("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    chk("out_err", out_err, e[64]);
                    chk("out_prod", out_prod, e[63:0]);
                end
                last_prod = out_prod; last_err = out_err;
                n_done++;
            end
            prev_hold = out_valid && !out_ready;
            prev_prod = out_prod; prev_err = out_err;
            if (in_valid && in_ready) begin
                exp_q.push_back(timeout_mode ? {1'b1, 64'd0}
                                             : {1'b0, 64'(in_mcand) * 64'(in_mlier)});
                ref_count++;
            end
            prev_start = mul_start; prev_mcand = mul_mcand; prev_mlier = mul_mlier;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
        logic acc;
        int budget;
        in_valid = 1'b1; in_mcand = a; in_mlier = b;
        budget = 0;
        do begin
            @(negedge clock);
            acc = in_ready;
            tick();
            budget++;
        end while (!acc && budget < 500);
        in_valid = 1'b0;
        if (!acc) chk("push_accept_timeout", acc, 1);
    endtask

    task automatic wait_done(input int target, input string tag);
        int budget = 0;
        while (n_done < target && budget < 3000) begin tick(); budget++; end
        chk(tag, n_done >= target, 1);
    endtask

    task automatic wait_start(input string tag);
        int budget = 0;
        while (!mul_start && budget < 200) begin tick(); budget++; end
        chk(tag, mul_start, 1);
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        int base, cyc;
        reset = 1'b1; in_valid = 1'b0; in_mcand = '0; in_mlier = '0;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_prod", out_prod, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_ops", {mul_mcand, mul_mlier}, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // 1: single job, launch timing and busy release
        base = n_done;
        push(32'd3, 32'd5);
        chk("t1_start_not_yet", mul_start, 0);
        tick();
        chk("t1_start_rise", mul_start, 1);
        chk("t1_busy", busy, 1);
        wait_done(base + 1, "t1_done");
        chk("t1_prod", last_prod, 64'd15);
        chk("t1_err", last_err, 0);
        repeat (3) tick();
        chk("t1_busy_low", busy, 0);

        // 2: corner operands
        base = n_done;
        push('1, '1);
        wait_done(base + 1, "t2a_done");
        chk("t2a_prod", last_prod, 64'hFFFF_FFFE_0000_0001);
        push(32'd0, 32'h1234);
        wait_done(base + 2, "t2b_done");
        chk("t2b_prod", last_prod, 64'd0);

        // 3: back-pressure fills the FIFO
        repeat (4) tick();
        base = n_done;
        dir_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) push(N'(i), N'(i));
        chk("t3_in_ready_full", in_ready, 0);
        chk("t3_count_full", fifo_count, DEPTH);
        cyc = 0;
        while (!out_valid && cyc < 200) begin tick(); cyc++; end
        chk("t3_first_held", out_valid, 1);
        repeat (5) tick();
        chk("t3_first_prod", out_prod, 64'd1);
        chk("t3_no_launch", mul_start, 0);

        // 5: pop and rejected push in the same cycle
        dir_rdy = 1'b1; in_valid = 1'b1; in_mcand = 32'd99; in_mlier = 32'd99;
        tick();
        chk("t5_count_before", fifo_count, DEPTH);
        chk("t5_ready_before", in_ready, 0);
        tick();
        in_valid = 1'b0;
        chk("t5_count_after", fifo_count, DEPTH - 1);
        chk("t5_launched", mul_start, 1);
        wait_done(base + 5, "t3_all_done");
        chk("t3_last_prod", last_prod, 64'd25);

        // 4: multiplier never completes
        repeat (3) tick();
        base = n_done;
        mul_en = 1'b0; timeout_mode = 1'b1;
        push(32'd7, 32'd9);
        wait_start("t4_start");
        cyc = 0;
        while (!out_valid && cyc < 200) begin tick(); cyc++; end
        chk("t4_timeout_cycles", cyc, TIMEOUT);
        chk("t4_err", out_err, 1);
        chk("t4_prod", out_prod, 0);
        mul_en = 1'b1; timeout_mode = 1'b0;
        push(32'd6, 32'd7);
        wait_done(base + 2, "t4_recover_done");
        chk("t4_recover_prod", last_prod, 64'd42);
        chk("t4_recover_err", last_err, 0);

        // Random traffic with random back-pressure
        base = n_done;
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            push(pick(), pick());
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_done(base + 24, "rand_done");
        rand_rdy = 1'b0; dir_rdy = 1'b1;
        repeat (4) tick();

        // 6: reset in the middle of a job
        mul_en = 1'b0; timeout_mode = 1'b1;
        push(32'd11, 32'd13);
        push(32'd17, 32'd19);
        wait_start("t6_start");
        repeat (10) tick();
        chk("t6_busy_run", busy, 1);
        chk("t6_queued", fifo_count, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_start", mul_start, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_busy", busy, 0);
        repeat (2) tick();
        reset = 1'b0;
        mul_en = 1'b1; timeout_mode = 1'b0;
        tick();
        base = n_done;
        in_mcand = pick(); in_mlier = pick();
        push(in_mcand, in_mlier);
        wait_done(base + 1, "t6_after_done");
        repeat (4) tick();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
